// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: shared state encoding and default widths for the transmit
// burst sequencer and its timer.
package tx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    TX   = 2'd2,
    TAIL = 2'd3
  } tx_state_e;

  localparam int          DEFAULT_ADDR_W = 14;
  localparam int          DEFAULT_TIME_W = 16;
  localparam logic [15:0] MISSCNT_MAX    = 16'hFFFF;

endpackage

// File: rtl/tx_seq_timer.sv
// tx_seq_timer: loadable down-counter shared by the LEAD and TAIL phases.
// A load takes priority; otherwise the count walks down to zero and parks.
module tx_seq_timer #(
  parameter int W = 16
) (
  input  logic         ref_clk,
  input  logic         ref_rstn,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  // Load a new interval or count down toward zero.
  always_ff @(posedge ref_clk or negedge ref_rstn) begin
    if (!ref_rstn) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tx_burst_sequencer.sv
// tx_burst_sequencer: one transmit burst per trigger edge -- PA enable lead
// time, waveform playback addresses, PA hold-off tail, then idle.
// Optional feature macro: TX_SEQ_MISSCNT_EN adds the missed_cnt port and a
// saturating count of triggers dropped while a burst is in progress.
module tx_burst_sequencer
  import tx_seq_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int TIME_W = DEFAULT_TIME_W
) (
  input  logic              ref_clk,
  input  logic              ref_rstn,
  input  logic              enable,
  input  logic              trig,
  input  logic [ADDR_W-1:0] txsmps,
  input  logic [TIME_W-1:0] lead_cycles,
  input  logic [TIME_W-1:0] tail_cycles,
  output logic [ADDR_W-1:0] tx_addr,
  output logic              tx_active,
  output logic              pa_en,
  output logic              busy,
  output logic              done
`ifdef TX_SEQ_MISSCNT_EN
  ,
  output logic [15:0]       missed_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  tx_state_e         state;
  tx_state_e         state_next;
  logic              trig_q;
  logic              trig_edge;
  logic              accept;
  logic              finish;
  logic              timer_load;
  logic [TIME_W-1:0] timer_value;
  logic              timer_zero;
  logic [ADDR_W-1:0] len_sh;
  logic [TIME_W-1:0] tail_sh;
  logic [ADDR_W-1:0] last_addr;

  assign trig_edge = trig & ~trig_q;
  assign last_addr = len_sh - ADDR_ONE;

  tx_seq_timer #(
    .W(TIME_W)
  ) u_timer (
    .ref_clk  (ref_clk),
    .ref_rstn (ref_rstn),
    .load     (timer_load),
    .value    (timer_value),
    .zero     (timer_zero)
  );

  // Next-state decode; enable low in any active phase forces an abort.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    finish      = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (trig_edge && enable && (txsmps != '0)) begin
          accept = 1'b1;
          if (lead_cycles != '0) begin
            state_next  = LEAD;
            timer_load  = 1'b1;
            timer_value = lead_cycles - TIME_ONE;
          end else begin
            state_next = TX;
          end
        end
      end
      LEAD: begin
        if (timer_zero) begin
          state_next = TX;
        end
      end
      TX: begin
        if (tx_addr == last_addr) begin
          if (tail_sh != '0) begin
            state_next  = TAIL;
            timer_load  = 1'b1;
            timer_value = tail_sh - TIME_ONE;
          end else begin
            state_next = IDLE;
            finish     = 1'b1;
          end
        end
      end
      TAIL: begin
        if (timer_zero) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if ((state != IDLE) && !enable) begin
      state_next = IDLE;
      finish     = 1'b0;
      timer_load = 1'b0;
    end
  end

  // State register and outputs, all registered from the next-state decode.
  always_ff @(posedge ref_clk or negedge ref_rstn) begin
    if (!ref_rstn) begin
      state     <= IDLE;
      pa_en     <= 1'b0;
      busy      <= 1'b0;
      tx_active <= 1'b0;
      tx_addr   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      pa_en     <= (state_next != IDLE);
      busy      <= (state_next != IDLE);
      tx_active <= (state_next == TX);
      done      <= finish;
      if ((state == TX) && (state_next == TX)) begin
        tx_addr <= tx_addr + ADDR_ONE;
      end else begin
        tx_addr <= '0;
      end
    end
  end

  // Trigger history for rising-edge detection.
  always_ff @(posedge ref_clk or negedge ref_rstn) begin
    if (!ref_rstn) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig;
    end
  end

  // Capture burst length and tail at acceptance so mid-burst config edits are
  // ignored; the lead count is consumed directly by the timer load.
  always_ff @(posedge ref_clk or negedge ref_rstn) begin
    if (!ref_rstn) begin
      len_sh  <= '0;
      tail_sh <= '0;
    end else if (accept) begin
      len_sh  <= txsmps;
      tail_sh <= tail_cycles;
    end
  end

`ifdef TX_SEQ_MISSCNT_EN
  // Count otherwise-valid triggers that arrive while a burst is running.
  always_ff @(posedge ref_clk or negedge ref_rstn) begin
    if (!ref_rstn) begin
      missed_cnt <= '0;
    end else if (trig_edge && enable && (txsmps != '0) && (state != IDLE)
                 && (missed_cnt != MISSCNT_MAX)) begin
      missed_cnt <= missed_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/tx_burst_sequencer.md
Name: tx_burst_sequencer

Overview:
- Sequences one transmit burst per trigger: PA enable lead time, then DAC waveform-memory playback, then PA hold-off tail, then idle.
- Drives the playback address bus of the DAC waveform memory (dac_0_addr into design_main) and the PA enable output, in the ref_clk domain.
- Sits between the register/control block (trig, burst config) and the DAC waveform memory.

Parameters:
- ADDR_W, 14, width of waveform address and sample count.
- TIME_W, 16, width of lead/tail cycle counts.

Ports:
- ref_clk  in  1  system clock, 215.04 MHz; all logic on rising edge.
- ref_rstn  in  1  asynchronous active-low reset.
- enable  in  1  level; low aborts any burst and blocks triggers.
- trig  in  1  trigger level; a rising edge (0 then 1 on consecutive samples) requests a burst.
- txsmps  in  ADDR_W  burst length in samples; 0 = reject trigger.
- lead_cycles  in  TIME_W  pa_en-to-first-sample delay in clocks.
- tail_cycles  in  TIME_W  pa_en hold after the last sample, in clocks.
- tx_addr  out  ADDR_W  waveform memory address.
- tx_active  out  1  high while tx_addr is a valid playback sample.
- pa_en  out  1  power-amplifier enable.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a burst completes normally.
- missed_cnt  out  16  saturating count of dropped triggers (TX_SEQ_MISSCNT_EN only).

Behaviour:
- Reset: state IDLE; tx_addr=0, tx_active=0, pa_en=0, busy=0, done=0, missed_cnt=0, trig history register=0. All outputs are registered.
- Edge detect: trig_q is registered every cycle. edge = trig & ~trig_q.
- States: IDLE, LEAD, TX, TAIL.
- IDLE: if edge & enable & txsmps!=0, latch txsmps/lead/tail into shadow registers. Next state is LEAD if lead!=0, else TX. pa_en=1 from the next cycle. Config inputs are ignored mid-burst.
- LEAD: a down-counter is loaded with lead-1. Exit to TX when the counter reaches 0, so pa_en precedes tx_active by exactly lead_cycles clocks.
- TX: tx_active=1, tx_addr=0,1,…,len-1, one per clock; len=txsmps gives exactly txsmps cycles. After the last address, exit to TAIL if tail!=0, else IDLE.
- TAIL: tx_active=0, tx_addr=0, pa_en=1 for tail_cycles clocks, then IDLE.
- Completion: on entry to IDLE from a normal finish, done=1 for one cycle and pa_en=0 on that same cycle.
- Address range: tx_addr never wraps within a burst. txsmps=2^ADDR_W-1 is the maximum length.
- Abort: enable sampled low in any non-IDLE state → IDLE on the next edge. All outputs return to their reset values except missed_cnt; no done pulse.
- Triggers while busy: an edge in any non-IDLE state is ignored. An edge on the done cycle is accepted (state is IDLE then).
- Rejected triggers: an edge with enable=0 or txsmps=0 is silently dropped and does not count as missed.
- Async reset mid-burst: immediate return to reset values, pa_en drops without a tail.

Optional Feature:
- TX_SEQ_MISSCNT_EN defined: missed_cnt port exists and increments by 1, saturating at 0xFFFF, for each accepted-edge-condition trigger (enable=1, txsmps!=0) arriving while busy. Cleared only by reset.
- Undefined: port and counter are absent; busy triggers are dropped with no record.

Decomposition:
- Package tx_seq_pkg: state enum (IDLE=2'd0, LEAD=2'd1, TX=2'd2, TAIL=2'd3), ADDR_W/TIME_W defaults, MISSCNT_MAX=16'hFFFF.
- One sub-module, tx_seq_timer: loadable down-counter (load, value, zero flag), used for both LEAD and TAIL.
- The TX address counter lives in the top module.

Test Plan:
- Nominal: txsmps=8, lead=3, tail=2, trig rises at cycle T → pa_en high T+1..T+13; tx_active T+4..T+11 with tx_addr 0..7; done pulse at T+14 with pa_en=0.
- Zero lead/tail: lead=0, tail=0, txsmps=4 → pa_en and tx_active both rise at T+1; tx_addr 0..3; done at T+5.
- Abort: enable dropped during TX at tx_addr=5 → next cycle pa_en=0, tx_active=0, tx_addr=0, busy=0, no done.
- Retrigger: trig held high across the burst → exactly one burst. A second rising edge during LEAD → ignored and missed_cnt=1 (MISSCNT_EN); edge on the done cycle → new burst starts.
- Rejects: txsmps=0 or enable=0 with trig edge → busy stays 0 and missed_cnt unchanged. Config changed mid-burst → burst length unaffected.
- Reset mid-TAIL: ref_rstn low asynchronously → all outputs 0 without waiting for a clock; the first trig after release starts a clean burst.
